// File: rtl/rv_wb_arb_pkg.sv
// Shared core constants and the writeback-entry layout used by the LSU result FIFO.
package rv_wb_arb_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREG   = 32;

    localparam int unsigned WB_ENTRY_W = REG_AW + XLEN;

    // FIFO entries are packed as {rd, data}; rd sits in the upper bits.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/rv_wb_fifo.sv
// Synchronous FIFO for buffered LSU writeback entries; head is read combinationally.
module rv_wb_fifo #(
    parameter int unsigned Width = 69,
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_d = count_q + 1'b1;
            else if (pop_i && !push_i) count_d = count_q - 1'b1;
        end
        full_d  = (count_d == CntW'(Depth));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/rv_wb_arb.sv
// Writeback arbiter: merges ALU and LSU results onto the single register-file write port
// and tracks outstanding LSU destinations in a pending scoreboard.
module rv_wb_arb
    import rv_wb_arb_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              alu_vld_i,
    input  logic [REG_AW-1:0] alu_rd_i,
    input  logic [XLEN-1:0]   alu_data_i,
    output logic              alu_rdy_o,
    input  logic              lsu_vld_i,
    input  logic [REG_AW-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]   lsu_data_i,
    output logic              lsu_rdy_o,
    input  logic              iss_vld_i,
    input  logic [REG_AW-1:0] iss_rd_i,
    output logic [NREG-1:0]   pend_o,
    output logic              wr_en_o,
    output logic [REG_AW-1:0] wr_reg_o,
    output logic [XLEN-1:0]   wr_data_o
);

    localparam int unsigned EntryW = REG_AW + XLEN;

    logic              fifo_full, fifo_empty;
    logic [EntryW-1:0] fifo_head;
    logic              rdy;
    logic              alu_fire, lsu_fire;
    logic              push, pop;
    logic              win_vld, win_lsu;
    logic [REG_AW-1:0] win_rd;
    logic [XLEN-1:0]   win_data;

    logic [NREG-1:0]   pend_q, pend_d;
    logic              wr_en_q;
    logic [REG_AW-1:0] wr_reg_q;
    logic [XLEN-1:0]   wr_data_q;

    // Readiness comes only from the registered full flag: no path from *_vld_i.
    assign rdy       = !fifo_full;
    assign alu_rdy_o = rdy;
    assign lsu_rdy_o = rdy;

    always_comb begin
        alu_fire = alu_vld_i && rdy;
        lsu_fire = lsu_vld_i && rdy;
        push     = 1'b0;
        pop      = 1'b0;
        win_vld  = 1'b0;
        win_lsu  = 1'b0;
        win_rd   = '0;
        win_data = '0;
        if (!flush_i) begin
            if (alu_fire) begin
                win_vld  = 1'b1;
                win_rd   = alu_rd_i;
                win_data = alu_data_i;
                push     = lsu_fire;
            end else if (!fifo_empty) begin
                pop      = 1'b1;
                win_vld  = 1'b1;
                win_lsu  = 1'b1;
                win_rd   = fifo_head[EntryW-1:XLEN];
                win_data = fifo_head[XLEN-1:0];
                push     = lsu_fire;
            end else if (lsu_fire) begin
                win_vld  = 1'b1;
                win_lsu  = 1'b1;
                win_rd   = lsu_rd_i;
                win_data = lsu_data_i;
            end
        end
    end

    // A new issue to the same register outranks the clear from an older load.
    always_comb begin
        pend_d = pend_q;
        if (win_lsu) pend_d[win_rd] = 1'b0;
        if (iss_vld_i && (iss_rd_i != '0)) pend_d[iss_rd_i] = 1'b1;
        if (flush_i) pend_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            pend_q  <= pend_d;
            wr_en_q <= win_vld && (win_rd != '0);
            if (win_vld) begin
                wr_reg_q  <= win_rd;
                wr_data_q <= win_data;
            end
        end
    end

    rv_wb_fifo #(
        .Width (EntryW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({lsu_rd_i, lsu_data_i}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pend_o    = pend_q;
    assign wr_en_o   = wr_en_q;
    assign wr_reg_o  = wr_reg_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_rv_wb_arb.sv
// Randomised and directed bench for rv_wb_arb against a queue-based reference model.
module tb_rv_wb_arb;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush_i;
    logic            alu_vld_i;
    logic [4:0]      alu_rd_i;
    logic [XLEN-1:0] alu_data_i;
    logic            alu_rdy_o;
    logic            lsu_vld_i;
    logic [4:0]      lsu_rd_i;
    logic [XLEN-1:0] lsu_data_i;
    logic            lsu_rdy_o;
    logic            iss_vld_i;
    logic [4:0]      iss_rd_i;
    logic [31:0]     pend_o;
    logic            wr_en_o;
    logic [4:0]      wr_reg_o;
    logic [XLEN-1:0] wr_data_o;

    rv_wb_arb #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .alu_vld_i  (alu_vld_i),
        .alu_rd_i   (alu_rd_i),
        .alu_data_i (alu_data_i),
        .alu_rdy_o  (alu_rdy_o),
        .lsu_vld_i  (lsu_vld_i),
        .lsu_rd_i   (lsu_rd_i),
        .lsu_data_i (lsu_data_i),
        .lsu_rdy_o  (lsu_rdy_o),
        .iss_vld_i  (iss_vld_i),
        .iss_rd_i   (iss_rd_i),
        .pend_o     (pend_o),
        .wr_en_o    (wr_en_o),
        .wr_reg_o   (wr_reg_o),
        .wr_data_o  (wr_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: buffered LSU results as a queue, plus expected port/scoreboard state.
    logic [XLEN+4:0] mq[$];
    logic            m_wr_en;
    logic [4:0]      m_wr_reg;
    logic [XLEN-1:0] m_wr_data;
    logic [31:0]     m_pend;
    bit              prev_rdy;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] obs,
                            input logic [XLEN-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [XLEN+4:0] e;
        bit              rdy, at, lt, win, win_lsu;
        logic [4:0]      wrd;
        logic [XLEN-1:0] wd;
        rdy      = (mq.size() < DEPTH);
        prev_rdy = rdy;
        win      = 0;
        win_lsu  = 0;
        wrd      = '0;
        wd       = '0;
        if (rst) begin
            mq.delete();
            m_wr_en   = 1'b0;
            m_wr_reg  = '0;
            m_wr_data = '0;
            m_pend    = '0;
        end else if (flush_i) begin
            mq.delete();
            m_pend  = '0;
            m_wr_en = 1'b0;
        end else begin
            at = alu_vld_i && rdy;
            lt = lsu_vld_i && rdy;
            if (at) begin
                win = 1; wrd = alu_rd_i; wd = alu_data_i;
                if (lt) mq.push_back({lsu_rd_i, lsu_data_i});
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                win = 1; win_lsu = 1; wrd = e[XLEN+4:XLEN]; wd = e[XLEN-1:0];
                if (lt) mq.push_back({lsu_rd_i, lsu_data_i});
            end else if (lt) begin
                win = 1; win_lsu = 1; wrd = lsu_rd_i; wd = lsu_data_i;
            end
            m_wr_en = win && (wrd != 0);
            if (win) begin
                m_wr_reg  = wrd;
                m_wr_data = wd;
            end
            if (win_lsu) m_pend[wrd] = 1'b0;
            if (iss_vld_i && iss_rd_i != 0) m_pend[iss_rd_i] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check_eq("alu_rdy", alu_rdy_o, (mq.size() < DEPTH));
        check_eq("lsu_rdy", lsu_rdy_o, (mq.size() < DEPTH));
        check_eq("wr_en", wr_en_o, m_wr_en);
        if (m_wr_en) begin
            check_eq("wr_reg", wr_reg_o, m_wr_reg);
            check_eq("wr_data", wr_data_o, m_wr_data);
        end
        check_eq("pend", pend_o, m_pend);
    endtask

    task automatic cyc();
        if (alu_vld_i && !rst && !flush_i)
            assert (!pend_o[alu_rd_i]) else $error("ALU write targets pending x%0d", alu_rd_i);
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_in(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                          input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                          input bit iv, input logic [4:0] ird, input bit fl);
        alu_vld_i = av; alu_rd_i = ard; alu_data_i = ad;
        lsu_vld_i = lv; lsu_rd_i = lrd; lsu_data_i = ld;
        iss_vld_i = iv; iss_rd_i = ird; flush_i = fl;
        cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Continuous ALU plus a stream of LSU results that obeys the hold-while-not-ready rule.
    task automatic fill_stream(input int alu_cycles, input int lsu_total);
        int sent = 0;
        alu_vld_i = 0; lsu_vld_i = 0; iss_vld_i = 0; flush_i = 0;
        for (int c = 0; c < alu_cycles; c++) begin
            if (lsu_vld_i && prev_rdy) sent++;
            if (!(alu_vld_i && !prev_rdy)) begin
                alu_vld_i = 1; alu_rd_i = 5'(16 + c); alu_data_i = 64'hA000 + 64'(c);
            end
            if (!(lsu_vld_i && !prev_rdy)) begin
                lsu_vld_i  = (sent < lsu_total);
                lsu_rd_i   = 5'(10 + sent);
                lsu_data_i = 64'hC0DE0 + 64'(sent);
            end
            cyc();
        end
    endtask

    task automatic rand_cycle();
        if (!(alu_vld_i && !prev_rdy)) begin
            int r = $urandom_range(15, 31);
            alu_vld_i  = ($urandom_range(0, 99) < 55);
            alu_rd_i   = (r == 15) ? 5'd0 : 5'(r);
            alu_data_i = {$urandom, $urandom};
        end
        if (!(lsu_vld_i && !prev_rdy)) begin
            lsu_vld_i  = ($urandom_range(0, 99) < 50);
            lsu_rd_i   = 5'($urandom_range(0, 15));
            lsu_data_i = {$urandom, $urandom};
        end
        iss_vld_i = ($urandom_range(0, 99) < 30);
        iss_rd_i  = 5'($urandom_range(0, 15));
        flush_i   = ($urandom_range(0, 99) < 3);
        rst       = ($urandom_range(0, 199) == 0);
        cyc();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        prev_rdy = 1;
        m_wr_en = 0; m_wr_reg = 0; m_wr_data = 0; m_pend = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        check_eq("reset_wr_reg", wr_reg_o, 0);
        check_eq("reset_wr_data", wr_data_o, 0);
        check_eq("reset_rdy", alu_rdy_o && lsu_rdy_o, 1);

        // ALU single write, then an x0 write that must not assert wr_en.
        set_in(1, 5, 64'h1234, 0, 0, 0, 0, 0, 0);
        check_eq("alu_wr_en", wr_en_o, 1);
        check_eq("alu_wr_reg", wr_reg_o, 5);
        check_eq("alu_wr_data", wr_data_o, 64'h1234);
        set_in(1, 0, 64'hFF, 0, 0, 0, 0, 0, 0);
        check_eq("x0_wr_en", wr_en_o, 0);
        idle(1);

        // Collision: ALU wins, LSU is buffered and written the next cycle.
        set_in(1, 3, 64'hA, 1, 7, 64'hB, 0, 0, 0);
        check_eq("coll_reg_alu", wr_reg_o, 3);
        check_eq("coll_lsu_rdy", lsu_rdy_o, 1);
        idle(1);
        check_eq("coll_reg_lsu", wr_reg_o, 7);
        check_eq("coll_data_lsu", wr_data_o, 64'hB);

        // Scoreboard set, clear on flow-through, and set-wins collision.
        set_in(0, 0, 0, 0, 0, 0, 1, 9, 0);
        check_eq("pend9_set", pend_o[9], 1);
        idle(2);
        set_in(0, 0, 0, 1, 9, 64'h99, 0, 0, 0);
        check_eq("pend9_wr_en", wr_en_o, 1);
        check_eq("pend9_clr", pend_o[9], 0);
        set_in(0, 0, 0, 0, 0, 0, 1, 9, 0);
        set_in(0, 0, 0, 1, 9, 64'h98, 1, 9, 0);
        check_eq("pend9_setwins", pend_o[9], 1);
        set_in(0, 0, 0, 1, 9, 64'h97, 0, 0, 0);
        check_eq("pend9_clr2", pend_o[9], 0);

        // Back-pressure: FIFO fills, drains in order once the ALU stops.
        fill_stream(8, 3);
        alu_vld_i = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(lsu_vld_i && !prev_rdy)) lsu_vld_i = 0;
            cyc();
        end
        check_eq("fill_drained", mq.size(), 0);

        // Flush with two buffered entries and pend = x4 | x8.
        set_in(0, 0, 0, 0, 0, 0, 1, 4, 0);
        set_in(0, 0, 0, 0, 0, 0, 1, 8, 0);
        set_in(1, 16, 64'h16, 1, 1, 64'h11, 0, 0, 0);
        set_in(1, 17, 64'h17, 1, 2, 64'h22, 0, 0, 0);
        check_eq("preflush_pend", pend_o, 32'h0000_0110);
        check_eq("preflush_full", alu_rdy_o, 0);
        set_in(1, 18, 64'h18, 1, 3, 64'h33, 1, 5, 1);
        check_eq("flush_wr_en", wr_en_o, 0);
        check_eq("flush_pend", pend_o, 0);
        check_eq("flush_rdy", alu_rdy_o && lsu_rdy_o, 1);
        idle(2);
        check_eq("flush_no_stale", wr_en_o, 0);

        // Reset with the FIFO full.
        set_in(0, 0, 0, 0, 0, 0, 1, 6, 0);
        fill_stream(2, 3);
        check_eq("prerst_full", lsu_rdy_o, 0);
        rst = 1;
        cyc();
        rst = 0;
        check_eq("rst_wr_en", wr_en_o, 0);
        check_eq("rst_wr_reg", wr_reg_o, 0);
        check_eq("rst_wr_data", wr_data_o, 0);
        check_eq("rst_pend", pend_o, 0);
        check_eq("rst_rdy", alu_rdy_o && lsu_rdy_o, 1);
        idle(4);
        check_eq("rst_no_stale", wr_en_o, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) rand_cycle();
        alu_vld_i = 0;
        for (int i = 0; i < 6; i++) begin
            if (!(lsu_vld_i && !prev_rdy)) lsu_vld_i = 0;
            iss_vld_i = 0;
            flush_i = 0;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_wb_arb.md
# rv_wb_arb

Writeback arbiter for the RV64 core: the write-side counterpart of the register file. Merges single-cycle ALU results and variable-latency load/store-unit (LSU) results into the register file's single write port (`wr_en`/`wr_reg`/`wr_data`). Buffers LSU results in a small FIFO. Maintains a per-register pending scoreboard that the issue stage uses for load-use hazard stalls.

## Interface
- `XLEN`, 64, data width.
- `DEPTH`, 2, LSU result FIFO entries (power of two, ≥2).

- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `flush_i` in 1: pipeline flush; drops buffered LSU results and clears the scoreboard.
- `alu_vld_i` in 1: ALU result valid.
- `alu_rd_i` in 5: ALU destination register.
- `alu_data_i` in XLEN: ALU result.
- `alu_rdy_o` out 1: ALU result accepted this cycle.
- `lsu_vld_i` in 1: LSU result valid.
- `lsu_rd_i` in 5: LSU destination register.
- `lsu_data_i` in XLEN: LSU result.
- `lsu_rdy_o` out 1: LSU result accepted this cycle.
- `iss_vld_i` in 1: a long-latency (LSU) instruction issued.
- `iss_rd_i` in 5: its destination register.
- `pend_o` out 32: scoreboard; bit n = xn awaits an LSU writeback.
- `wr_en_o` out 1: register file write enable.
- `wr_reg_o` out 5: register file write index.
- `wr_data_o` out XLEN: register file write data.

## Operation
- **Handshakes.** Transfer occurs on `vld && rdy`. A source holds `rd`/`data` stable while `vld && !rdy`.
- **Readiness.** `lsu_rdy_o = !full`. `alu_rdy_o = !full`. Both derive from the registered FIFO count only; no combinational path from `*_vld_i`.
- **Arbitration, per cycle:**
  - An ALU transfer wins. An LSU transfer in the same cycle is pushed into the FIFO.
  - With no ALU transfer: the FIFO head is popped and written. If the FIFO is empty, an incoming LSU transfer flows straight through, bypassing the FIFO.
  - A full FIFO deasserts `alu_rdy_o`, which guarantees the head drains.
- **x0 handling.** A winner with rd==0 is consumed, but `wr_en_o` stays 0.
- **Simultaneous push and pop.** Allowed; the count is unchanged.
- **Scoreboard set.** `iss_vld_i && iss_rd_i!=0` sets `pend[iss_rd_i]`.
- **Scoreboard clear.** An LSU result that wins the port clears `pend[rd]`.
- **Scoreboard collision.** Set and clear of the same bit in one cycle: the set wins, because the newer issue is still outstanding.
- **Caller precondition.** The issue stage stalls any instruction whose rd has `pend` set, so an ALU write never targets a pending register. The bench asserts this.
- **Flush.**
  - Empties the FIFO and zeroes `pend`.
  - ALU/LSU transfers in the flush cycle are discarded; the ready signals are still driven and the data is dropped.
  - An `iss_vld_i` in the flush cycle is ignored.
  - `wr_en_o`=0 the following cycle.
- **Reset.** Same as flush, plus all outputs are zeroed.

## Timing
- **Reset values:** `wr_en_o`=0, `wr_reg_o`=0, `wr_data_o`=0, `pend_o`=0, count=0. `alu_rdy_o`=1 and `lsu_rdy_o`=1 in the first cycle after reset.
- **Registered outputs.** `wr_*` are registered: an ALU transfer or flow-through LSU transfer in cycle N writes at N+1.
- **Buffered LSU latency.** An LSU entry buffered at N is written no earlier than N+2.
- **`pend_o` timing.** `pend_o` is registered. A set at issue cycle N is visible at N+1. A clear is visible in the same cycle `wr_en_o` for that write asserts.
- **Register file forwarding.** The register file reads synchronously, so a read in the cycle `wr_en_o`=1 returns old data. The consumer forwards from `wr_*`; this block adds no bypass.
- **Throughput.** One write per cycle. No bubbles while any source is valid and not in flush.
- **Full FIFO.** With the FIFO full for one cycle, the next cycle is guaranteed to pop the head.

## Structure
- **Shared constants.** Add to the core package/include: `XLEN`, `REG_AW`=5, `NREG`=32. A writeback-entry field layout `{rd[4:0], data[XLEN-1:0]}`, used by the FIFO.
- **Sub-module `rv_wb_fifo`.**
  - Synchronous FIFO, `DEPTH` × (5+XLEN), with registered count and full/empty flags.
  - Has push/pop/clear inputs.
  - Read data is combinational from the head entry.
- **Top level.** Arbiter, output registers, and scoreboard live in `rv_wb_arb`.

## Test plan
- **ALU single write.** `alu_vld_i`=1, rd=5, data=0x1234 at cycle 1 → `wr_en_o`=1, `wr_reg_o`=5, `wr_data_o`=0x1234 at cycle 2. At cycle 3, rd=0, data=0xFF → `wr_en_o`=0.
- **Collision.** ALU (rd=3, 0xA) and LSU (rd=7, 0xB) valid at cycle 1 → x3 written at cycle 2, x7 written at cycle 3, `lsu_rdy_o`=1 throughout.
- **Scoreboard.**
  - `iss_vld_i` rd=9 at cycle 1 → `pend_o[9]`=1 at cycle 2.
  - LSU rd=9 flow-through at cycle 4 → `wr_en_o`=1 and `pend_o[9]`=0 at cycle 5.
  - Issue rd=9 in the same cycle as that writeback → `pend_o[9]` stays 1.
- **Fill/back-pressure.** Continuous ALU valid plus 3 LSU results with DEPTH=2 → FIFO fills, `alu_rdy_o`/`lsu_rdy_o`=0 for one cycle, head drains. All 3 LSU values are written in order, none lost or duplicated.
- **Flush.** 2 LSU entries buffered and `pend_o`=0x0000_0110, assert `flush_i` → next cycle `wr_en_o`=0, `pend_o`=0, FIFO empty, `*_rdy_o`=1.
- **Reset mid-operation.** Repeat the back-pressure stream, then assert `rst` with the FIFO full → next cycle all outputs are at their reset values and no stale write appears afterward.
